calc_key_ctrl: RTL and testbench



---
 rtl/calc_key_ctrl_if.sv | 33 +++
 rtl/calc_key_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 tb/tb_calc_key_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_key_ctrl_if.sv
// Mouse inputs and display/status outputs of the CalcuTEC key controller.
// result_neg is present only when CALC_NEG_EN is defined.
interface calc_key_ctrl_if;
  logic [9:0]  mouse_x;
  logic [9:0]  mouse_y;
  logic        mouse_btn;
  logic [13:0] dibujar;
  logic [6:0]  signo;
  logic        busy;
  logic        error;
  logic        key_strobe;
`ifdef CALC_NEG_EN
  logic        result_neg;

  modport master (
    output mouse_x, mouse_y, mouse_btn,
    input  dibujar, signo, busy, error, key_strobe, result_neg
  );
  modport slave (
    input  mouse_x, mouse_y, mouse_btn,
    output dibujar, signo, busy, error, key_strobe, result_neg
  );
`else
  modport master (
    output mouse_x, mouse_y, mouse_btn,
    input  dibujar, signo, busy, error, key_strobe
  );
  modport slave (
    input  mouse_x, mouse_y, mouse_btn,
    output dibujar, signo, busy, error, key_strobe
  );
`endif
endinterface

// File: rtl/calc_key_ctrl.sv
// CalcuTEC keypad hit-test, operand/operator FSM and arithmetic (restoring divider); CALC_NEG_EN adds result_neg.
// Latency: click -> key_strobe 3 edges, outputs 1 edge later; DIV/MOD busy 15 cycles, others 1.
// Backpressure: none upstream; keys other than Clear arriving while busy are dropped.
module calc_key_ctrl #(
  parameter int KEY_SIZE  = 64,
  parameter int KEY_X0    = 90,
  parameter int KEY_Y0    = 150,
  parameter int COL_PITCH = 128,
  parameter int ROW_PITCH = 89,
  parameter int CLR_X0    = 560,
  parameter int CLR_Y0    = 150
) (
  input logic            clk,
  input logic            reset,
  calc_key_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_ENTER_A, ST_OP_SEL, ST_ENTER_B, ST_COMPUTE, ST_RESULT, ST_ERROR
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD
  } op_t;

  localparam logic [4:0] K_ADD = 5'd10;
  localparam logic [4:0] K_SUB = 5'd11;
  localparam logic [4:0] K_MUL = 5'd12;
  localparam logic [4:0] K_DIV = 5'd13;
  localparam logic [4:0] K_MOD = 5'd14;
  localparam logic [4:0] K_EQ  = 5'd15;
  localparam logic [4:0] K_CLR = 5'd16;
  localparam logic [3:0] DIV_STEPS = 4'd14;

  function automatic logic [6:0] op_glyph(input op_t o);
    case (o)
      OP_ADD:  return 7'd96;
      OP_SUB:  return 7'd97;
      OP_MUL:  return 7'd98;
      OP_DIV:  return 7'd100;
      OP_MOD:  return 7'd101;
      default: return 7'd32;
    endcase
  endfunction

  // ---------------- input capture ----------------
  logic btn_s1, btn_s2, btn_s3;
  logic click;

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      btn_s3 <= 1'b0;
    end else begin
      btn_s1 <= bus.mouse_btn;
      btn_s2 <= btn_s1;
      btn_s3 <= btn_s2;
    end
  end

  assign click = btn_s2 & ~btn_s3;

  int         mx, my;
  logic [3:0] col_hit, row_hit;
  logic       clr_hit;
  logic [1:0] row_idx, col_idx;
  logic       hit;
  logic [4:0] hit_code;

  assign mx = {22'd0, bus.mouse_x};
  assign my = {22'd0, bus.mouse_y};

  always_comb begin
    col_hit = '0;
    row_hit = '0;
    row_idx = '0;
    col_idx = '0;
    for (int i = 0; i < 4; i++) begin
      col_hit[i] = (mx >= KEY_X0 + i * COL_PITCH) && (mx <= KEY_X0 + i * COL_PITCH + KEY_SIZE);
      row_hit[i] = (my >= KEY_Y0 + i * ROW_PITCH) && (my <= KEY_Y0 + i * ROW_PITCH + KEY_SIZE);
      if (row_hit[i]) row_idx = 2'(i);
      if (col_hit[i]) col_idx = 2'(i);
    end
    clr_hit = (mx >= CLR_X0) && (mx <= CLR_X0 + KEY_SIZE) &&
              (my >= CLR_Y0) && (my <= CLR_Y0 + KEY_SIZE);
  end

  always_comb begin
    hit      = 1'b0;
    hit_code = '0;
    if (clr_hit) begin
      hit      = 1'b1;
      hit_code = K_CLR;
    end else if (|row_hit && |col_hit) begin
      hit = 1'b1;
      case ({row_idx, col_idx})
        4'h0: hit_code = 5'd1;
        4'h1: hit_code = 5'd2;
        4'h2: hit_code = 5'd3;
        4'h3: hit_code = K_ADD;
        4'h4: hit_code = 5'd4;
        4'h5: hit_code = 5'd5;
        4'h6: hit_code = 5'd6;
        4'h7: hit_code = K_SUB;
        4'h8: hit_code = 5'd7;
        4'h9: hit_code = 5'd8;
        4'hA: hit_code = 5'd9;
        4'hB: hit_code = K_MUL;
        4'hC: hit_code = 5'd0;
        4'hD: hit_code = K_EQ;
        4'hE: hit_code = K_DIV;
        default: hit_code = K_MOD;
      endcase
    end
  end

  logic       key_strobe_q;
  logic [4:0] key_code_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_strobe_q <= 1'b0;
      key_code_q   <= '0;
    end else begin
      key_strobe_q <= click & hit;
      key_code_q   <= hit_code;
    end
  end

  // ---------------- sequencing state ----------------
  state_t      state_q, state_n;
  logic [13:0] a_q, a_n, b_q, b_n;
  op_t         op_q, op_n, pend_q, pend_n, key_op;
  logic        to_res_q, to_res_n;
  logic [3:0]  cnt_q, cnt_n;
  logic [13:0] rem_q, rem_n, quo_q, quo_n;
  logic [13:0] dibujar_q, dibujar_n;
  logic [6:0]  signo_q, signo_n;
  logic        busy_q, error_q;
`ifdef CALC_NEG_EN
  logic        neg_q, neg_n, res_neg;
`endif

  logic        is_digit, is_op, is_eq, is_clr, is_divop, step;
  logic [3:0]  digit;
  logic [14:0] sum, rem_sh;
  logic [27:0] prod;
  logic        div_ge;
  logic [13:0] res_val;
  logic        res_err;

  assign digit    = key_code_q[3:0];
  assign is_digit = key_strobe_q && (key_code_q <= 5'd9);
  assign is_op    = key_strobe_q && (key_code_q >= K_ADD) && (key_code_q <= K_MOD);
  assign is_eq    = key_strobe_q && (key_code_q == K_EQ);
  assign is_clr   = key_strobe_q && (key_code_q == K_CLR);
  assign is_divop = (op_q == OP_DIV) || (op_q == OP_MOD);
  assign step     = is_divop && (cnt_q != DIV_STEPS);

  assign sum    = {1'b0, a_q} + {1'b0, b_q};
  assign prod   = {14'd0, a_q} * {14'd0, b_q};
  assign rem_sh = {rem_q, quo_q[13]};
  assign div_ge = rem_sh >= {1'b0, b_q};

  always_comb begin
    key_op = OP_NONE;
    case (key_code_q)
      K_ADD:   key_op = OP_ADD;
      K_SUB:   key_op = OP_SUB;
      K_MUL:   key_op = OP_MUL;
      K_DIV:   key_op = OP_DIV;
      K_MOD:   key_op = OP_MOD;
      default: key_op = OP_NONE;
    endcase
  end

  always_comb begin
    res_val = '0;
    res_err = 1'b0;
`ifdef CALC_NEG_EN
    res_neg = 1'b0;
`endif
    case (op_q)
      OP_ADD: begin
        res_val = sum[13:0];
        res_err = sum > 15'd9999;
      end
      OP_SUB: begin
        if (b_q > a_q) begin
`ifdef CALC_NEG_EN
          res_val = b_q - a_q;
          res_neg = 1'b1;
`else
          res_err = 1'b1;
`endif
        end else begin
          res_val = a_q - b_q;
        end
      end
      OP_MUL: begin
        res_val = prod[13:0];
        res_err = prod > 28'd9999;
      end
      OP_DIV: begin
        res_val = quo_q;
        res_err = (b_q == 14'd0) || (quo_q > 14'd9999);
      end
      OP_MOD: begin
        res_val = rem_q;
        res_err = b_q == 14'd0;
      end
      default: res_err = 1'b0;
    endcase
  end

  always_comb begin
    state_n  = state_q;
    a_n      = a_q;
    b_n      = b_q;
    op_n     = op_q;
    pend_n   = pend_q;
    to_res_n = to_res_q;
    cnt_n    = cnt_q;
    rem_n    = rem_q;
    quo_n    = quo_q;
`ifdef CALC_NEG_EN
    neg_n    = neg_q;
`endif
    if (is_clr) begin
      state_n = ST_ENTER_A;
      a_n     = '0;
      b_n     = '0;
      op_n    = OP_NONE;
`ifdef CALC_NEG_EN
      neg_n   = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_ENTER_A, ST_OP_SEL, ST_ENTER_B, ST_RESULT: begin
          if (is_digit) begin
`ifdef CALC_NEG_EN
            neg_n = 1'b0;
`endif
            case (state_q)
              ST_ENTER_A: if (a_q <= 14'd999) a_n = a_q * 14'd10 + {10'd0, digit};
              ST_ENTER_B: if (b_q <= 14'd999) b_n = b_q * 14'd10 + {10'd0, digit};
              ST_OP_SEL: begin
                b_n     = {10'd0, digit};
                state_n = ST_ENTER_B;
              end
              default: begin
                a_n     = {10'd0, digit};
                op_n    = OP_NONE;
                state_n = ST_ENTER_A;
              end
            endcase
          end else if ((is_op || is_eq) && state_q == ST_ENTER_B) begin
            // Divider starts with the dividend in the quotient shift register.
            pend_n   = key_op;
            to_res_n = is_eq;
            cnt_n    = '0;
            rem_n    = '0;
            quo_n    = a_q;
            state_n  = ST_COMPUTE;
          end else if (is_op) begin
            op_n    = key_op;
            state_n = ST_OP_SEL;
          end
        end
        ST_COMPUTE: begin
          if (step) begin
            rem_n = div_ge ? (rem_sh[13:0] - b_q) : rem_sh[13:0];
            quo_n = {quo_q[12:0], div_ge};
            cnt_n = cnt_q + 4'd1;
          end else if (res_err) begin
            state_n = ST_ERROR;
          end else begin
            a_n = res_val;
`ifdef CALC_NEG_EN
            if (res_neg) neg_n = 1'b1;
`endif
            if (to_res_q) begin
              state_n = ST_RESULT;
            end else begin
              op_n    = pend_q;
              state_n = ST_OP_SEL;
            end
          end
        end
        default: state_n = state_q;
      endcase
    end
  end

  always_comb begin
    dibujar_n = dibujar_q;
    signo_n   = op_glyph(op_n);
    case (state_n)
      ST_ENTER_A, ST_OP_SEL, ST_RESULT: dibujar_n = a_n;
      ST_ENTER_B:                       dibujar_n = b_n;
      ST_ERROR: begin
        dibujar_n = '0;
        signo_n   = 7'd69;
      end
      default:                          dibujar_n = dibujar_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_ENTER_A;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_NONE;
      pend_q    <= OP_NONE;
      to_res_q  <= 1'b0;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dibujar_q <= '0;
      signo_q   <= 7'd32;
      busy_q    <= 1'b0;
      error_q   <= 1'b0;
`ifdef CALC_NEG_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_n;
      a_q       <= a_n;
      b_q       <= b_n;
      op_q      <= op_n;
      pend_q    <= pend_n;
      to_res_q  <= to_res_n;
      cnt_q     <= cnt_n;
      rem_q     <= rem_n;
      quo_q     <= quo_n;
      dibujar_q <= dibujar_n;
      signo_q   <= signo_n;
      busy_q    <= state_n == ST_COMPUTE;
      error_q   <= state_n == ST_ERROR;
`ifdef CALC_NEG_EN
      neg_q     <= neg_n;
`endif
    end
  end

  assign bus.dibujar    = dibujar_q;
  assign bus.signo      = signo_q;
  assign bus.busy       = busy_q;
  assign bus.error      = error_q;
  assign bus.key_strobe = key_strobe_q;
`ifdef CALC_NEG_EN
  assign bus.result_neg = neg_q;
`endif

endmodule

// File: tb/tb_calc_key_ctrl.sv
// Directed key sequences for calc_key_ctrl; expected display per key is queued at issue time
// and checked by an independent monitor once the key's effect (and any computation) settles.
module tb_calc_key_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  calc_key_ctrl_if bus();
  calc_key_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    int dib;
    int sig;
    int err;
    int bsy;
    bit skip;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  localparam int K_ADD = 10, K_SUB = 11, K_MUL = 12, K_DIV = 13, K_MOD = 14, K_EQ = 15, K_CLR = 16;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic key_pos(input int code, output int x, output int y);
    int r, c;
    r = 0; c = 0;
    if (code >= 1 && code <= 9) begin r = (code - 1) / 3; c = (code - 1) % 3; end
    else case (code)
      0:     begin r = 3; c = 0; end
      K_ADD: begin r = 0; c = 3; end
      K_SUB: begin r = 1; c = 3; end
      K_MUL: begin r = 2; c = 3; end
      K_EQ:  begin r = 3; c = 1; end
      K_DIV: begin r = 3; c = 2; end
      K_MOD: begin r = 3; c = 3; end
      default: ;
    endcase
    x = 90 + c * 128 + 20;
    y = 150 + r * 89 + 20;
    if (code == K_CLR) begin x = 570; y = 160; end
  endtask

  task automatic expect_key(input int dib, input int sig, input int err, input int bsy, input bit skip);
    exp_t e;
    e.dib = dib; e.sig = sig; e.err = err; e.bsy = bsy; e.skip = skip;
    exp_q.push_back(e);
  endtask

  task automatic click(input int x, input int y, input int hold);
    @(negedge clk);
    bus.mouse_x   = 10'(x);
    bus.mouse_y   = 10'(y);
    bus.mouse_btn = 1'b1;
    repeat (hold) @(negedge clk);
    bus.mouse_btn = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  task automatic press_at(input int x, input int y, input int dib, input int sig, input int err, input int bsy);
    expect_key(dib, sig, err, bsy, 1'b0);
    click(x, y, 4);
  endtask

  task automatic press(input int code, input int dib, input int sig, input int err, input int bsy);
    int x, y;
    key_pos(code, x, y);
    press_at(x, y, dib, sig, err, bsy);
  endtask

  // Monitor: one record per key_strobe; outputs compared after the update edge and after busy drops.
  initial begin : monitor
    bit   pending;
    int   bc;
    exp_t e;
    pending = 1'b0;
    forever begin
      if (!pending) begin
        @(negedge clk);
        while (!bus.key_strobe) @(negedge clk);
      end
      pending = 1'b0;
      @(negedge clk);
      bc = 0;
      while (bus.busy && bc < 40) begin
        if (bus.key_strobe) begin
          pending = 1'b1;
          break;
        end
        bc++;
        @(negedge clk);
      end
      if (bc >= 40) begin
        checks++; errors++;
        $display("FAIL busy_bound: busy high for %0d cycles, required to drop", bc);
      end
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_strobe: got a key_strobe, required none");
      end else begin
        e = exp_q.pop_front();
        if (!e.skip) begin
          chk("dibujar", int'(bus.dibujar), e.dib);
          chk("signo", int'(bus.signo), e.sig);
          chk("error", int'(bus.error), e.err);
          chk("busy_cycles", bc, e.bsy);
        end
      end
    end
  end

  initial begin : stim
    int lat, n, x, y;
    reset = 1'b1;
    bus.mouse_x = '0; bus.mouse_y = '0; bus.mouse_btn = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_dibujar", int'(bus.dibujar), 0);
    chk("rst_signo", int'(bus.signo), 32);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_error", int'(bus.error), 0);
    chk("rst_strobe", int'(bus.key_strobe), 0);
`ifdef CALC_NEG_EN
    chk("rst_neg", int'(bus.result_neg), 0);
`endif

    // 1: latency and single strobe for a long hold
    expect_key(1, 32, 0, 0, 1'b0);
    @(negedge clk);
    bus.mouse_x = 10'd100; bus.mouse_y = 10'd160; bus.mouse_btn = 1'b1;
    lat = 0;
    while (!bus.key_strobe && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("strobe_latency", lat, 3);
    repeat (50) @(negedge clk);
    bus.mouse_btn = 1'b0;
    repeat (30) @(negedge clk);
    press(K_CLR, 0, 32, 0, 0);

    // 2: 12 + 30
    press(1, 1, 32, 0, 0);
    press(2, 12, 32, 0, 0);
    press(K_ADD, 12, 96, 0, 0);
    press(3, 3, 96, 0, 0);
    press(0, 30, 96, 0, 0);
    press(K_EQ, 42, 96, 0, 1);

    // 3: 4-digit cap, overflow error, ignored digit, clear
    press(K_CLR, 0, 32, 0, 0);
    press(9, 9, 32, 0, 0);
    press(9, 99, 32, 0, 0);
    press(9, 999, 32, 0, 0);
    press(9, 9999, 32, 0, 0);
    press(9, 9999, 32, 0, 0);
    press(K_MUL, 9999, 98, 0, 0);
    press(2, 2, 98, 0, 0);
    press(K_EQ, 0, 69, 1, 1);
    press(5, 0, 69, 1, 0);
    press(K_CLR, 0, 32, 0, 0);

    // 4: 100 / 7 = 14, then 14 mod 5 = 4
    press(1, 1, 32, 0, 0);
    press(0, 10, 32, 0, 0);
    press(0, 100, 32, 0, 0);
    press(K_DIV, 100, 100, 0, 0);
    press(7, 7, 100, 0, 0);
    press(K_EQ, 14, 100, 0, 15);
    press(K_MOD, 14, 101, 0, 0);
    press(5, 5, 101, 0, 0);
    press(K_EQ, 4, 101, 0, 15);

    // 5: Clear during a divide
    press(K_CLR, 0, 32, 0, 0);
    press(9, 9, 32, 0, 0);
    press(0, 90, 32, 0, 0);
    press(0, 900, 32, 0, 0);
    press(0, 9000, 32, 0, 0);
    press(K_DIV, 9000, 100, 0, 0);
    press(3, 3, 100, 0, 0);
    expect_key(0, 0, 0, 0, 1'b1);
    key_pos(K_EQ, x, y);
    @(negedge clk);
    bus.mouse_x = 10'(x); bus.mouse_y = 10'(y); bus.mouse_btn = 1'b1;
    repeat (2) @(negedge clk);
    bus.mouse_btn = 1'b0;
    n = 0;
    while (!bus.busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("div_busy_seen", int'(bus.busy), 1);
    expect_key(0, 32, 0, 0, 1'b0);
    bus.mouse_x = 10'd570; bus.mouse_y = 10'd160; bus.mouse_btn = 1'b1;
    repeat (4) @(negedge clk);
    bus.mouse_btn = 1'b0;
    repeat (30) @(negedge clk);
    press(2, 2, 32, 0, 0);

    // 6: 5 - 8
    press(K_CLR, 0, 32, 0, 0);
    press(5, 5, 32, 0, 0);
    press(K_SUB, 5, 97, 0, 0);
    press(8, 8, 97, 0, 0);
`ifdef CALC_NEG_EN
    press(K_EQ, 3, 97, 0, 1);
    chk("result_neg_set", int'(bus.result_neg), 1);
    press(K_CLR, 0, 32, 0, 0);
    chk("result_neg_clr", int'(bus.result_neg), 0);
`else
    press(K_EQ, 0, 69, 1, 1);
    press(K_CLR, 0, 32, 0, 0);
`endif
    click(160, 160, 4);
    click(155, 160, 4);
    click(100, 215, 4);

    // Inclusive box edges
    press_at(154, 214, 1, 32, 0, 0);
    press_at(90, 150, 11, 32, 0, 0);
    press_at(538, 481, 11, 101, 0, 0);
    press_at(624, 214, 0, 32, 0, 0);

    // Chaining: 2 + 3, then * 4, then - 7, then new entry
    press(2, 2, 32, 0, 0);
    press(K_ADD, 2, 96, 0, 0);
    press(3, 3, 96, 0, 0);
    press(K_MUL, 5, 98, 0, 1);
    press(4, 4, 98, 0, 0);
    press(K_EQ, 20, 98, 0, 1);
    press(K_SUB, 20, 97, 0, 0);
    press(7, 7, 97, 0, 0);
    press(K_EQ, 13, 97, 0, 1);
    press(6, 6, 32, 0, 0);

    repeat (40) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
